add_share_arbiter: RTL and testbench

Round-robin arbiter that time-shares one NBITS-wide adder among NREQ requesters (e.g. PC increment, branch-target calc, debug unit). Each requester uses a valid/ready handshake. Accepted operands are added and registered into a single output slot tagged with the requester index. The consumer drains the slot through its own valid/ready handshake. Sustains one add per cycle when the consumer does not stall.

---
 rtl/add_share_arbiter.sv | 100 ++++++++++
 tb/tb_add_share_arbiter.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/add_share_arbiter.sv
// Round-robin arbiter time-sharing one adder among NREQ requesters.
// Each sum is registered into a single output slot tagged with its requester index.
module add_share_arbiter #(
  parameter int NBITS = 32,
  parameter int NREQ  = 4,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*NBITS-1:0] req_a,
  input  logic [NREQ*NBITS-1:0] req_b,
  output logic [NREQ-1:0]       req_ready,
  output logic                  res_valid,
  output logic [NBITS-1:0]      res_data,
  output logic                  res_ovf,
  output logic [IDW-1:0]        res_id,
  input  logic                  res_ready
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} slot_state_t;

  slot_state_t      state, state_nxt;
  logic [IDW-1:0]   rr_ptr, rr_ptr_nxt;
  logic [IDW-1:0]   grant_idx;
  logic [IDW:0]     cand_wide;
  logic             grant_found;
  logic             can_accept;
  logic             accept;
  logic [NBITS-1:0] op_a, op_b, sum;
  logic             sum_ovf;

  // Cyclic search from rr_ptr; the wrap is a subtraction so NREQ need not be a power of two.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand_wide   = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand_wide = {1'b0, rr_ptr} + (IDW+1)'(k);
      if (cand_wide >= (IDW+1)'(NREQ))
        cand_wide = cand_wide - (IDW+1)'(NREQ);
      if (!grant_found && req_valid[cand_wide[IDW-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = cand_wide[IDW-1:0];
      end
    end
  end

  // A full slot that drains this cycle may be refilled in the same cycle.
  assign can_accept = (state == EMPTY) || res_ready;
  assign accept     = rst_n && can_accept && grant_found;

  always_comb begin
    req_ready = '0;
    if (accept)
      req_ready[grant_idx] = 1'b1;
  end

  assign op_a    = req_a[int'(grant_idx)*NBITS +: NBITS];
  assign op_b    = req_b[int'(grant_idx)*NBITS +: NBITS];
  assign sum     = op_a + op_b;
  assign sum_ovf = (op_a[NBITS-1] == op_b[NBITS-1]) && (sum[NBITS-1] != op_a[NBITS-1]);

  assign rr_ptr_nxt = (grant_idx == IDW'(NREQ-1)) ? '0 : grant_idx + 1'b1;

  always_comb begin
    state_nxt = state;
    if (accept)
      state_nxt = FULL;
    else if ((state == FULL) && res_ready)
      state_nxt = EMPTY;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= EMPTY;
      rr_ptr <= '0;
    end else begin
      state <= state_nxt;
      if (accept)
        rr_ptr <= rr_ptr_nxt;
    end
  end

  // Payload only moves on accept, so a plain drain leaves the last result visible.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_data <= '0;
      res_ovf  <= 1'b0;
      res_id   <= '0;
    end else if (accept) begin
      res_data <= sum;
      res_ovf  <= sum_ovf;
      res_id   <= grant_idx;
    end
  end

  assign res_valid = (state == FULL);

endmodule

// File: tb/tb_add_share_arbiter.sv
// Self-checking bench for add_share_arbiter: vector table with a result scoreboard,
// plus hand-written sequences for the 3-requester wrap and mid-operation reset.
module tb_add_share_arbiter;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [127:0] req_a;
  logic [127:0] req_b;
  logic [3:0]  req_ready;
  logic        res_valid;
  logic [31:0] res_data;
  logic        res_ovf;
  logic [1:0]  res_id;
  logic        res_ready;

  logic [2:0]  req_valid3;
  logic [23:0] req_a3;
  logic [23:0] req_b3;
  logic [2:0]  req_ready3;
  logic        res_valid3;
  logic [7:0]  res_data3;
  logic        res_ovf3;
  logic [1:0]  res_id3;
  logic        res_ready3;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [3:0]  valid;
    logic        rdy;
    logic [3:0]  exp_ready;
    logic        exp_resv;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_data;
    logic        exp_ovf;
    logic [1:0]  exp_id;
  } row_t;

  typedef struct packed {
    logic [1:0]  id;
    logic [31:0] data;
    logic        ovf;
  } sb_t;

  row_t vec [19];
  sb_t  sb_q [$];

  add_share_arbiter #(.NBITS(32), .NREQ(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .res_valid(res_valid), .res_data(res_data),
    .res_ovf(res_ovf), .res_id(res_id), .res_ready(res_ready)
  );

  add_share_arbiter #(.NBITS(8), .NREQ(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid3), .req_a(req_a3), .req_b(req_b3),
    .req_ready(req_ready3), .res_valid(res_valid3), .res_data(res_data3),
    .res_ovf(res_ovf3), .res_id(res_id3), .res_ready(res_ready3)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic row_t mk(input logic [3:0] v, input logic rdy, input logic [3:0] er,
                              input logic rv, input logic [31:0] a, input logic [31:0] b,
                              input logic [31:0] d, input logic o, input logic [1:0] id);
    row_t r;
    r.valid = v; r.rdy = rdy; r.exp_ready = er; r.exp_resv = rv;
    r.a = a; r.b = b; r.exp_data = d; r.exp_ovf = o; r.exp_id = id;
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Granted lane gets the row operands; every other lane gets junk the adder must ignore.
  task automatic applyStimulus(input row_t r);
    req_valid = r.valid;
    res_ready = r.rdy;
    for (int i = 0; i < 4; i++) begin
      if (r.exp_ready[i]) begin
        req_a[i*32 +: 32] = r.a;
        req_b[i*32 +: 32] = r.b;
      end else begin
        req_a[i*32 +: 32] = 32'hDEAD_0000 + 32'(i);
        req_b[i*32 +: 32] = 32'h0BAD_0000 + 32'(i);
      end
    end
  endtask

  task automatic runRow(input int n, input row_t r);
    sb_t e;
    sb_t s;
    applyStimulus(r);
    @(negedge clk);
    checkOutput($sformatf("req_ready[%0d]", n), 64'(req_ready), 64'(r.exp_ready));
    checkOutput($sformatf("res_valid[%0d]", n), 64'(res_valid), 64'(r.exp_resv));
    if (res_valid) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL result[%0d]: got id %0d data %0h with no result expected", n, res_id, res_data);
      end else begin
        e = sb_q[0];
        checkOutput($sformatf("res_id[%0d]", n), 64'(res_id), 64'(e.id));
        checkOutput($sformatf("res_data[%0d]", n), 64'(res_data), 64'(e.data));
        checkOutput($sformatf("res_ovf[%0d]", n), 64'(res_ovf), 64'(e.ovf));
        if (res_ready)
          void'(sb_q.pop_front());
      end
    end
    if (r.exp_ready != 4'b0000) begin
      s.id = r.exp_id; s.data = r.exp_data; s.ovf = r.exp_ovf;
      sb_q.push_back(s);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    vec[0]  = mk(4'b1111, 1'b1, 4'b0001, 1'b0, 32'h10, 32'h20, 32'h30, 1'b0, 2'd0);
    vec[1]  = mk(4'b0100, 1'b1, 4'b0100, 1'b1, 32'd5, 32'd7, 32'd12, 1'b0, 2'd2);
    vec[2]  = mk(4'b0000, 1'b1, 4'b0000, 1'b1, 32'h0, 32'h0, 32'h0, 1'b0, 2'd0);
    vec[3]  = mk(4'b0010, 1'b1, 4'b0010, 1'b0, 32'h7FFFFFFF, 32'h1, 32'h80000000, 1'b1, 2'd1);
    vec[4]  = mk(4'b0010, 1'b1, 4'b0010, 1'b1, 32'hFFFFFFFF, 32'h1, 32'h00000000, 1'b0, 2'd1);
    vec[5]  = mk(4'b1000, 1'b1, 4'b1000, 1'b1, 32'h80000000, 32'h80000000, 32'h0, 1'b1, 2'd3);
    vec[6]  = mk(4'b1111, 1'b1, 4'b0001, 1'b1, 32'd1, 32'd1, 32'd2, 1'b0, 2'd0);
    vec[7]  = mk(4'b1111, 1'b1, 4'b0010, 1'b1, 32'd2, 32'd2, 32'd4, 1'b0, 2'd1);
    vec[8]  = mk(4'b1111, 1'b1, 4'b0100, 1'b1, 32'd3, 32'd3, 32'd6, 1'b0, 2'd2);
    vec[9]  = mk(4'b1111, 1'b1, 4'b1000, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0, 2'd3);
    vec[10] = mk(4'b1111, 1'b1, 4'b0001, 1'b1, 32'h40000000, 32'h40000000, 32'h80000000, 1'b1, 2'd0);
    vec[11] = mk(4'b1111, 1'b1, 4'b0010, 1'b1, 32'h12345678, 32'h11111111, 32'h23456789, 1'b0, 2'd1);
    vec[12] = mk(4'b1111, 1'b0, 4'b0000, 1'b1, 32'h0, 32'h0, 32'h0, 1'b0, 2'd0);
    vec[13] = mk(4'b1111, 1'b0, 4'b0000, 1'b1, 32'h0, 32'h0, 32'h0, 1'b0, 2'd0);
    vec[14] = mk(4'b1111, 1'b0, 4'b0000, 1'b1, 32'h0, 32'h0, 32'h0, 1'b0, 2'd0);
    vec[15] = mk(4'b1111, 1'b1, 4'b0100, 1'b1, 32'h3, 32'hFFFFFFFD, 32'h0, 1'b0, 2'd2);
    vec[16] = mk(4'b0000, 1'b0, 4'b0000, 1'b1, 32'h0, 32'h0, 32'h0, 1'b0, 2'd0);
    vec[17] = mk(4'b0000, 1'b1, 4'b0000, 1'b1, 32'h0, 32'h0, 32'h0, 1'b0, 2'd0);
    vec[18] = mk(4'b0000, 1'b1, 4'b0000, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 2'd0);

    rst_n = 1'b0;
    req_valid = 4'b1111;
    req_a = '0;
    req_b = '0;
    res_ready = 1'b1;
    req_valid3 = 3'b000;
    req_a3 = '0;
    req_b3 = '0;
    res_ready3 = 1'b1;

    #12;
    checkOutput("rst_req_ready", 64'(req_ready), 64'h0);
    checkOutput("rst_res_valid", 64'(res_valid), 64'h0);
    checkOutput("rst_res_data", 64'(res_data), 64'h0);
    checkOutput("rst_res_id", 64'(res_id), 64'h0);
    checkOutput("rst_res_ovf", 64'(res_ovf), 64'h0);
    req_valid = 4'b0000;
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int n = 0; n < 19; n++)
      runRow(n, vec[n]);
    checkOutput("sb_empty", 64'(sb_q.size()), 64'h0);

    // Three requesters: steer rr_ptr to 2, then watch it wrap 2 -> 0 -> 1.
    req_valid3 = 3'b010;
    req_a3 = {8'hEE, 8'h01, 8'hEE};
    req_b3 = {8'hEE, 8'h02, 8'hEE};
    @(negedge clk);
    checkOutput("n3_ready_c0", 64'(req_ready3), 64'b010);
    @(posedge clk);
    #1;
    req_valid3 = 3'b101;
    req_a3 = {8'h7F, 8'hEE, 8'h80};
    req_b3 = {8'h01, 8'hEE, 8'h80};
    @(negedge clk);
    checkOutput("n3_ready_c1", 64'(req_ready3), 64'b100);
    checkOutput("n3_valid_c1", 64'(res_valid3), 64'h1);
    checkOutput("n3_data_c1", 64'(res_data3), 64'h03);
    checkOutput("n3_id_c1", 64'(res_id3), 64'd1);
    @(posedge clk);
    #1;
    @(negedge clk);
    checkOutput("n3_ready_c2", 64'(req_ready3), 64'b001);
    checkOutput("n3_data_c2", 64'(res_data3), 64'h80);
    checkOutput("n3_ovf_c2", 64'(res_ovf3), 64'h1);
    checkOutput("n3_id_c2", 64'(res_id3), 64'd2);
    @(posedge clk);
    #1;
    @(negedge clk);
    checkOutput("n3_ready_c3", 64'(req_ready3), 64'b100);
    checkOutput("n3_data_c3", 64'(res_data3), 64'h00);
    checkOutput("n3_ovf_c3", 64'(res_ovf3), 64'h1);
    checkOutput("n3_id_c3", 64'(res_id3), 64'd0);
    @(posedge clk);
    #1;
    req_valid3 = 3'b000;
    @(negedge clk);
    checkOutput("n3_id_c4", 64'(res_id3), 64'd2);
    @(posedge clk);
    #1;

    // Fill the slot under backpressure, then reset between edges.
    req_valid = 4'b0010;
    res_ready = 1'b0;
    req_a = '0;
    req_b = '0;
    @(negedge clk);
    checkOutput("mr_ready_fill", 64'(req_ready), 64'b0010);
    @(posedge clk);
    #1;
    req_valid = 4'b1010;
    res_ready = 1'b1;
    #1;
    checkOutput("mr_full", 64'(res_valid), 64'h1);
    rst_n = 1'b0;
    #1;
    checkOutput("mr_res_valid", 64'(res_valid), 64'h0);
    checkOutput("mr_req_ready", 64'(req_ready), 64'h0);
    checkOutput("mr_res_id", 64'(res_id), 64'h0);
    rst_n = 1'b1;
    #1;
    checkOutput("mr_first_grant", 64'(req_ready), 64'b0010);
    @(posedge clk);
    #1;
    req_valid = 4'b0000;
    @(negedge clk);
    checkOutput("mr_result_id", 64'(res_id), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
